// File: rtl/song_sequencer.sv
// song_sequencer: walks a song held in a synchronous ROM and issues one-cycle
// load pulses (note + duration) to the polyphonic note distributor.
// Chain entries (advance=0) load back-to-back; advance entries hold for their
// duration in beats. A duration of 0 marks the end of the song.
// Optional feature macro: SONG_LOOP_EN (song restarts at idx 0 instead of
// stopping in DONE; song_done_o becomes a one-clock pulse at each loop point).
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for play after reset or song change while paused
// FETCH  | rom_addr_o presents {song, idx}; ROM answers next clock
// DECODE | rom_data_i valid; load pulse for non-rest, non-end entries
// WAIT   | advance entry holding; counts beats down to zero
// DONE   | end of song reached; song_done_o high, no further loads
module song_sequencer #(
  parameter int SONG_SEL_W = 2,
  parameter int NOTE_IDX_W = 7,
  parameter int ROM_DATA_W = 13
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             play_i,
  input  logic                             beat_i,
  input  logic [SONG_SEL_W-1:0]            song_sel_i,
  output logic [SONG_SEL_W+NOTE_IDX_W-1:0] rom_addr_o,
  input  logic [ROM_DATA_W-1:0]            rom_data_i,
  output logic                             load_new_note_o,
  output logic [5:0]                       note_to_load_o,
  output logic [5:0]                       duration_to_load_o,
  output logic                             song_done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [NOTE_IDX_W-1:0]   idx_q;
  logic [5:0]              cnt_q;
  logic [5:0]              note_q;
  logic [5:0]              dur_q;
  logic                    done_q;
  logic [SONG_SEL_W-1:0]   song_q;

  logic       song_chg;
  logic       rom_adv;
  logic [5:0] rom_note;
  logic [5:0] rom_dur;
  logic       is_decode;
  logic       is_end;
  logic       last_idx;
  logic       load;
  logic       entry_done;
  logic       song_end;

  // Decode of the current ROM word and of the entry-completion conditions.
  always_comb begin
    song_chg   = (song_sel_i != song_q);
    rom_adv    = rom_data_i[ROM_DATA_W-1];
    rom_note   = rom_data_i[11:6];
    rom_dur    = rom_data_i[5:0];
    is_decode  = (state_q == DECODE);
    is_end     = (rom_dur == 6'd0);
    last_idx   = &idx_q;
    // Load is asserted during DECODE itself, so an async reset kills it at once
    // and a song change arriving in the same cycle suppresses it.
    load       = is_decode && !song_chg && !is_end && (rom_note != 6'd0);
    entry_done = (is_decode && !is_end && !rom_adv) ||
                 ((state_q == WAIT) && beat_i && play_i && (cnt_q <= 6'd1));
    song_end   = (is_decode && is_end) || (entry_done && last_idx);
  end

  assign rom_addr_o         = {song_sel_i, idx_q};
  assign load_new_note_o    = load;
  assign note_to_load_o     = load ? rom_note : note_q;
  assign duration_to_load_o = load ? rom_dur  : dur_q;
  assign song_done_o        = done_q;

  // Sequencer FSM: song change has priority over every state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      done_q  <= 1'b0;
      song_q  <= '0;
    end else begin
      song_q <= song_sel_i;
`ifdef SONG_LOOP_EN
      done_q <= 1'b0;
`endif
      if (song_chg) begin
        idx_q   <= '0;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        state_q <= play_i ? FETCH : IDLE;
      end else begin
        if (load) begin
          note_q <= rom_note;
          dur_q  <= rom_dur;
        end
        if (song_end) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
`ifdef SONG_LOOP_EN
          idx_q   <= '0;
          state_q <= FETCH;
`else
          state_q <= DONE;
`endif
        end else if (entry_done) begin
          cnt_q   <= '0;
          idx_q   <= idx_q + {{(NOTE_IDX_W-1){1'b0}}, 1'b1};
          state_q <= FETCH;
        end else begin
          case (state_q)
            IDLE:    if (play_i) state_q <= FETCH;
            FETCH:   if (play_i) state_q <= DECODE;
            DECODE: begin
              cnt_q   <= rom_dur;
              state_q <= WAIT;
            end
            WAIT:    if (beat_i && play_i) cnt_q <= cnt_q - 6'd1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed testbench for song_sequencer with a behavioural synchronous ROM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic        beat;
  logic [1:0]  song_sel;
  logic [8:0]  rom_addr;
  logic [12:0] rom_data;
  logic        load;
  logic [5:0]  note;
  logic [5:0]  dur;
  logic        done;

  logic [12:0] rom [0:511];

  int n_checks = 0;
  int n_errors = 0;
  int n_loads  = 0;
  int n_b2b    = 0;
  logic prev_load = 1'b0;
  int ld_snap;

  int el [7] = '{0, 1, 0, 1, 0, 1, 0};
  int en [7] = '{0, 10, 0, 14, 0, 17, 0};

  song_sequencer dut (
    .clk_i              (clk),
    .reset_ni           (reset_n),
    .play_i             (play),
    .beat_i             (beat),
    .song_sel_i         (song_sel),
    .rom_addr_o         (rom_addr),
    .rom_data_i         (rom_data),
    .load_new_note_o    (load),
    .note_to_load_o     (note),
    .duration_to_load_o (dur),
    .song_done_o        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    if (load) n_loads++;
    if (load && prev_load) n_b2b++;
    prev_load = load;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic beats(input int n);
    repeat (n) begin
      beat = 1'b1;
      @(negedge clk);
    end
    beat = 1'b0;
  endtask

  function automatic logic [12:0] ent(input bit a, input int n, input int d);
    logic [5:0] nn;
    logic [5:0] dd;
    nn = n[5:0];
    dd = d[5:0];
    return {a, nn, dd};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = '0;
  endtask

  task automatic reset_dut();
    play     = 1'b0;
    beat     = 1'b0;
    song_sel = 2'd0;
    reset_n  = 1'b0;
    clear_rom();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values
    reset_n  = 1'b0;
    play     = 1'b0;
    beat     = 1'b0;
    song_sel = 2'd0;
    clear_rom();
    #1;
    chk("rst_addr", rom_addr, 9'h000);
    chk("rst_load", load, 1'b0);
    chk("rst_note", note, 6'd0);
    chk("rst_dur",  dur,  6'd0);
    chk("rst_done", done, 1'b0);

    // Single advance entry, then a chain entry, then end marker
    rom[0] = ent(1, 20, 4);
    rom[1] = ent(0, 30, 5);
    tick();
    reset_n = 1'b1;
    tick();
    play = 1'b1;
    tick();
    chk("t1_fetch_addr", rom_addr, 9'h000);
    chk("t1_fetch_load", load, 1'b0);
    tick();
    chk("t1_load", load, 1'b1);
    chk("t1_note", note, 6'd20);
    chk("t1_dur",  dur,  6'd4);
    tick();
    chk("t1_wait_load", load, 1'b0);
    chk("t1_note_held", note, 6'd20);
    beats(3);
    chk("t1_wait3_addr", rom_addr, 9'h000);
    beats(1);
    chk("t1_beat4_addr", rom_addr, 9'h001);
    chk("t1_beat4_load", load, 1'b0);
    tick();
    chk("t1_chain_load", load, 1'b1);
    chk("t1_chain_note", note, 6'd30);
    chk("t1_chain_dur",  dur,  6'd5);
    tick();
    chk("t1_fetch2_addr", rom_addr, 9'h002);
    tick();
    chk("t1_end_load", load, 1'b0);
    chk("t1_end_done_pre", done, 1'b0);
    tick();
    chk("t1_done", done, 1'b1);
`ifdef SONG_LOOP_EN
    chk("t1_loop_addr", rom_addr, 9'h000);
    tick();
    chk("t1_done_pulse", done, 1'b0);
`else
    chk("t1_done_addr", rom_addr, 9'h002);
    ld_snap = n_loads;
    tick(5);
    chk("t1_no_more_loads", n_loads - ld_snap, 0);
    chk("t1_done_hold", done, 1'b1);
    chk("t1_done_addr_hold", rom_addr, 9'h002);
`endif

    // Chord: three chained loads spaced two clocks apart
    reset_dut();
    rom[0] = ent(0, 10, 8);
    rom[1] = ent(0, 14, 8);
    rom[2] = ent(1, 17, 8);
    play = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("t2_load_%0d", k), load, el[k]);
      if (el[k] == 1) chk($sformatf("t2_note_%0d", k), note, en[k]);
    end
    chk("t2_last_dur", dur, 6'd8);
    beats(7);
    chk("t2_wait7_addr", rom_addr, 9'h002);
    beats(1);
    chk("t2_wait8_addr", rom_addr, 9'h003);

    // Pause during WAIT, then end marker
    reset_dut();
    rom[0] = ent(1, 20, 4);
    play = 1'b1;
    tick(3);
    beats(2);
    play = 1'b0;
    ld_snap = n_loads;
    beats(10);
    chk("t3_pause_addr", rom_addr, 9'h000);
    chk("t3_pause_loads", n_loads - ld_snap, 0);
    play = 1'b1;
    beats(1);
    chk("t3_resume1_addr", rom_addr, 9'h000);
    beats(1);
    chk("t3_resume2_addr", rom_addr, 9'h001);
    tick();
    chk("t3_end_load", load, 1'b0);
    tick();
    chk("t3_done", done, 1'b1);
`ifdef SONG_LOOP_EN
    chk("t3_loop_addr", rom_addr, 9'h000);
`else
    chk("t3_done_addr", rom_addr, 9'h001);
`endif
    song_sel = 2'd1;
    tick();
    chk("t3_chg_done", done, 1'b0);
    chk("t3_chg_addr", rom_addr, 9'h080);

    // Song change during WAIT
    reset_dut();
    rom[0]   = ent(1, 20, 4);
    rom[256] = ent(1, 33, 2);
    play = 1'b1;
    tick(3);
    beats(1);
    song_sel = 2'd2;
    tick();
    chk("t5_addr", rom_addr, 9'h100);
    chk("t5_load", load, 1'b0);
    chk("t5_done", done, 1'b0);
    tick();
    chk("t5_new_load", load, 1'b1);
    chk("t5_new_note", note, 6'd33);
    chk("t5_new_dur",  dur,  6'd2);
    tick();
    beats(1);
    chk("t5_wait1_addr", rom_addr, 9'h100);
    beats(1);
    chk("t5_wait2_addr", rom_addr, 9'h101);

    // Async reset during DECODE, then a rest entry
    reset_dut();
    rom[0] = ent(1, 20, 4);
    play = 1'b1;
    tick(2);
    chk("t6_pre_load", load, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_load", load, 1'b0);
    chk("t6_async_note", note, 6'd0);
    chk("t6_async_addr", rom_addr, 9'h000);
    rom[0] = ent(1, 0, 3);
    rom[1] = ent(1, 25, 1);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    chk("t6_rest_load", load, 1'b0);
    chk("t6_rest_note", note, 6'd0);
    tick();
    beats(2);
    chk("t6_rest2_addr", rom_addr, 9'h000);
    beats(1);
    chk("t6_rest3_addr", rom_addr, 9'h001);
    tick();
    chk("t6_after_load", load, 1'b1);
    chk("t6_after_note", note, 6'd25);
    chk("t6_after_dur",  dur,  6'd1);

    // Song change in the DECODE cycle suppresses that load
    reset_dut();
    rom[0]   = ent(1, 20, 4);
    rom[256] = ent(1, 33, 2);
    play = 1'b1;
    tick(2);
    chk("t7_pre_load", load, 1'b1);
    song_sel = 2'd2;
    #1;
    chk("t7_suppressed", load, 1'b0);
    tick();
    chk("t7_addr", rom_addr, 9'h100);
    chk("t7_fetch_load", load, 1'b0);
    tick();
    chk("t7_new_load", load, 1'b1);
    chk("t7_new_note", note, 6'd33);

    chk("no_back_to_back", n_b2b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream feeder of the polyphonic note distributor: walks a song stored in a synchronous ROM and issues one-cycle load_new_note pulses with note/duration.
- Supports chords: entries flagged "chain" load back-to-back without waiting; an "advance" entry loads and then holds for its duration in beats.
- Pauses with play, restarts on song change, and flags end of song.

Parameters:
- SONG_SEL_W, 2, width of song select; 4 songs.
- NOTE_IDX_W, 7, entries per song = 2^NOTE_IDX_W = 128.
- ROM_DATA_W, 13, ROM word width: [12] advance, [11:6] note, [5:0] duration.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- play  in  1  1 = run, 0 = pause (freeze beat wait and fetches)
- beat  in  1  one-cycle 48 Hz beat strobe from the beat generator
- song_sel  in  SONG_SEL_W  selected song
- rom_addr  out  SONG_SEL_W+NOTE_IDX_W  {song_sel, idx}; ROM data valid one clk later
- rom_data  in  ROM_DATA_W  ROM word for the address presented on the previous cycle
- load_new_note  out  1  one-cycle pulse: note_to_load/duration_to_load valid
- note_to_load  out  6  note number; 0 = rest
- duration_to_load  out  6  duration in beats
- song_done  out  1  level; high in DONE

Behaviour:
- Reset (reset=0, async): state IDLE, idx=0, beat counter=0, load_new_note=0, note_to_load=0, duration_to_load=0, song_done=0, rom_addr={song_sel,0}.
- States: IDLE, FETCH, DECODE, WAIT, DONE.
- IDLE: play=1 -> FETCH next clk.
- FETCH: rom_addr={song_sel,idx}; -> DECODE next clk (1-cycle ROM latency). If play=0, remain in FETCH.
- DECODE: examine rom_data.
  - Duration==0: end marker; no pulse; -> DONE.
  - Note!=0: load_new_note=1 this cycle; note/duration registered and held until next load.
  - Note==0 (rest): no pulse, but wait still honoured.
  - advance=0 (chain): idx+1 -> FETCH. Chained loads are therefore spaced 2 clks apart.
  - advance=1: counter=duration -> WAIT.
- WAIT: counter decrements on each clk with beat=1 and play=1. When counter reaches 0 (the beat that brings it from 1 to 0), idx+1 -> FETCH on next clk. beat while play=0 is ignored.
- Index wrap: after the entry at idx=127 is consumed (chain or wait complete), go to DONE instead of wrapping to 0.
- DONE: song_done=1; no pulses; rom_addr holds.
- song_sel change: compare against registered copy. Any change in any state forces idx=0, counter=0, state FETCH (if play=1) else IDLE, song_done=0, next clk.
  - Song change wins over a simultaneous DECODE: that cycle's load pulse is suppressed.
- Pause: play=0 in DECODE completes that decode (pulse allowed), then freezes in the next state.
- Reset mid-song: all state cleared immediately; resumes at idx 0.
- load_new_note is never high two consecutive clks.

Optional Feature:
- Macro SONG_LOOP_EN.
- Defined: end marker or index wrap sets idx=0 -> FETCH; DONE never entered; song_done pulses high one clk at each loop point.
- Undefined: behaviour as above; DONE is terminal until song_sel change or reset.

Test Plan:
- Reset then play=1, song 0 ROM[0]={1,6'd20,6'd4} -> rom_addr=0, load pulse 2 clks after play with note 20/dur 4; next fetch only after 4th beat.
- Chord: ROM[0..2]={0,10,8},{0,14,8},{1,17,8} -> three pulses at clks 2,4,6 with notes 10,14,17; then WAIT 8 beats.
- Pause: play drops after 2 of 4 beats, 10 beats strobe, play returns -> 2 more beats needed; no loads during pause.
- End marker ROM[1] dur 0 -> song_done=1 after entry 0 completes; no further pulses; with SONG_LOOP_EN, rom_addr returns to 0 and song_done is a 1-clk pulse.
- song_sel 0->2 during WAIT -> next clk FETCH with rom_addr=9'h100, song_done=0, counter cleared.
- Async reset asserted mid-DECODE -> load_new_note=0 immediately without clk edge; rest entry {1,0,3} produces no pulse but 3-beat wait.
